// File: rtl/pipe_hazard_ctrl_pkg.sv
// hazard_pkg: shared state type, register constants and load-use compare for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, WAIT} ctrl_state_t;
  localparam logic [4:0] REG_X0 = 5'd0;
  function automatic logic lu_detect(input logic mem_r, input logic [4:0] wr_addr, rs1_addr, rs2_addr,
                                     input logic use_rs1, use_rs2);
    return mem_r && (wr_addr != REG_X0) &&
           ((use_rs1 && rs1_addr == wr_addr) || (use_rs2 && rs2_addr == wr_addr));
  endfunction
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: wrapping counters of stall cycles and flush events
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(stall_inc);
      flush_cnt <= flush_cnt + CNT_W'(flush_inc);
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with hazard counters
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_r,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_branch_taken,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_stall,
  output logic             redirect_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  ctrl_state_t state;
  logic [2:0]  flush_ctr;
  logic        pend_flush;
  logic        mwait, lu, run_like, take, stall_all, bubble, fl;
  always_comb begin
    mwait     = imem_wait | dmem_wait;
    lu        = lu_detect(ex_mem_r, ex_wr_addr, id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2);
    run_like  = (state == RUN) || (state == WAIT);
    // a wait release replays a branch that arrived while the pipeline was frozen
    take      = ex_branch_taken || (state == WAIT && pend_flush);
    stall_all = rst && mwait;
    redirect_en = rst && run_like && !mwait && take;
    bubble    = rst && run_like && !mwait && !take && lu;
    fl        = rst && state == FLUSH && !mwait;
    pc_stall     = stall_all || bubble;
    IF_ID_stall  = stall_all || bubble;
    IF_ID_flush  = redirect_en || fl;
    ID_EX_stall  = stall_all;
    ID_EX_flush  = redirect_en || fl || bubble;
    EX_MEM_stall = stall_all;
    MEM_WB_stall = stall_all;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= RUN;
      flush_ctr  <= '0;
      pend_flush <= 1'b0;
    end else if (mwait) begin
      if (state != FLUSH) begin
        state      <= WAIT;
        pend_flush <= pend_flush || ex_branch_taken;
      end
    end else if (state == FLUSH) begin
      flush_ctr <= flush_ctr - 3'd1;
      state     <= (flush_ctr == 3'd1) ? RUN : FLUSH;
    end else begin
      pend_flush <= 1'b0;
      state      <= (take && FLUSH_CYCLES > 1) ? FLUSH : RUN;
      flush_ctr  <= (take && FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
    end
  end
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (stall_all || bubble),
    .flush_inc (redirect_en),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the stall and flush inputs of the PC register and the IF_ID, ID_EX, EX_MEM and MEM_WB registers from three sources: EX-stage branch resolution, ID/EX load-use hazards, and instruction/data memory wait.
- Owns multi-cycle flush sequencing, so pipeline registers implement only single-cycle stall/flush. It also holds pending flushes across memory waits and keeps hazard performance counters.

Parameters:
- FLUSH_CYCLES, 2, cycles IF_ID/ID_EX flush is held after a taken branch/jump (1..7).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-low: state is cleared on a clk rising edge while rst=0.
- id_rs1_addr  in  5  rs1 of the instruction in ID.
- id_rs2_addr  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_mem_r  in  1  instruction in EX is a load.
- ex_wr_addr  in  5  rd of the instruction in EX.
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle (redirect PC).
- imem_wait  in  1  instruction fetch not complete.
- dmem_wait  in  1  data access in MEM not complete.
- pc_stall  out  1  hold PC.
- IF_ID_stall  out  1  hold IF_ID.
- IF_ID_flush  out  1  clear IF_ID.
- ID_EX_stall  out  1  hold ID_EX.
- ID_EX_flush  out  1  clear ID_EX (bubble).
- EX_MEM_stall  out  1  hold EX_MEM.
- MEM_WB_stall  out  1  hold MEM_WB.
- redirect_en  out  1  PC takes branch target this cycle.
- stall_cnt  out  CNT_W  cycles lost to load-use or memory wait.
- flush_cnt  out  CNT_W  flush events, counted once per taken branch.

Behaviour:
- Outputs are combinational from the registered state and current inputs. State is updated on the clk rising edge.
- While rst=0, all stall/flush/redirect outputs are 0 and nothing is counted. At the edge: state=RUN, flush_ctr=0, pend_flush=0, stall_cnt=0, flush_cnt=0.
- Definitions:
  - mwait = imem_wait | dmem_wait.
  - lu = ex_mem_r & (ex_wr_addr!=0) & ((id_use_rs1 & id_rs1_addr==ex_wr_addr) | (id_use_rs2 & id_rs2_addr==ex_wr_addr)).
- Priority in any state: mwait > flush > load-use.
- States: RUN, FLUSH, WAIT.
- RUN:
  - If mwait: all five stalls=1, no flush, no redirect. If ex_branch_taken is also set, set pend_flush=1. Go to WAIT.
  - Else if ex_branch_taken: redirect_en=1, IF_ID_flush=1, ID_EX_flush=1, flush_cnt+=1. If FLUSH_CYCLES>1, go to FLUSH with flush_ctr=FLUSH_CYCLES-1; else stay in RUN.
  - Else if lu: pc_stall=1, IF_ID_stall=1, ID_EX_flush=1, stall_cnt+=1. Stay in RUN; the bubble in EX clears lu next cycle.
  - Else: all outputs 0.
- FLUSH:
  - Assert IF_ID_flush=1 and ID_EX_flush=1; no stalls; redirect_en=0; lu is ignored.
  - flush_ctr decrements each cycle; return to RUN when it reaches 0 (after FLUSH_CYCLES-1 cycles).
  - If mwait: all stalls=1 and flushes=0. flush_ctr is frozen (not decremented) and the FSM stays in FLUSH.
  - ex_branch_taken is ignored, since EX holds a bubble.
- WAIT:
  - Outputs while mwait: all stalls=1, no flush, stall_cnt+=1 per cycle.
  - ex_branch_taken while in WAIT also sets pend_flush.
  - When mwait drops:
    - pend_flush=1: behave exactly as RUN with ex_branch_taken (redirect, flush, flush_cnt+=1, possibly enter FLUSH) and clear pend_flush.
    - pend_flush=0: evaluate lu as in RUN and return to RUN.
- Both RUN and WAIT count the entry cycle of a memory stall, so stall_cnt+=1 for every cycle in which all stalls=1 or in which a load-use bubble is inserted.
- Counters wrap modulo 2^CNT_W.
- A reset mid-sequence (FLUSH, WAIT, pend_flush set) discards the pending flush.
- Stall and flush of the same register are never asserted together.

Decomposition:
- Package hazard_pkg:
  - enum ctrl_state_t {RUN, FLUSH, WAIT}.
  - Localparam REG_X0 = 5'd0.
  - Function lu_detect (pure combinational compare).
- Sub-module hazard_perf_cnt holds the two wrapping counters. Its inputs are stall_inc and flush_inc; its reset is the same synchronous active-low rst.

Test Plan:
- Load-use: ex_mem_r=1, ex_wr_addr=5, id_rs2_addr=5, id_use_rs2=1 → pc_stall=IF_ID_stall=ID_EX_flush=1 for one cycle, stall_cnt=1. Repeat with ex_wr_addr=0 → no stall.
- Taken branch, FLUSH_CYCLES=2: ex_branch_taken pulse → redirect_en=1 and both flushes=1 in cycle 0; both flushes=1 in cycle 1, redirect=0; cycle 2 all 0; flush_cnt=1.
- Branch plus dmem_wait for 3 cycles in the same cycle → 3 cycles all stalls=1, no redirect. Cycle 4: redirect_en=1 and flushes, then one more FLUSH cycle. stall_cnt=3, flush_cnt=1.
- imem_wait asserted in the second FLUSH cycle for 2 cycles → stalls=1, flushes=0, flush_ctr frozen. After release, one FLUSH cycle completes, then RUN.
- Branch and lu in the same cycle → flush wins: ID_EX_flush=1, pc_stall=0, stall_cnt unchanged.
- rst=0 asserted while in WAIT with pend_flush=1 → after release all outputs 0, counters 0, no redirect when mwait=0.
